tlp_txcmd_mfifo: RTL
====================

// Module: tlp_txcmd_mfifo
// PURPOSE
//  Multi-channel TX command FIFO for the AXI-PCIe TLP transmit path. Buffers TLP command
//  descriptors (MWr, MRd, Cpl) in independent per-channel FIFOs and drains them through
//  one round-robin arbitrated output to the TLP TX engine. Adds per-channel fill level,
//  almost-full backpressure and a sticky protocol-error flag.
// PARAMETERS
//  C_CHANNELS     3   number of command channels (1..8)
//  C_DATA_WIDTH   64  command descriptor width, bits
//  C_DEPTH_LOG2   4   log2 of per-channel FIFO depth (depth 16)
//  C_AFULL_THRESH 12  level at or above which in_afull[ch] asserts
//  C_CH_W         2   width of channel id, >= clog2(C_CHANNELS)
// PORTS
//  clk        in   1                              core clock, all logic rising edge
//  rst        in   1                              reset, asynchronous, active-high
//  in_valid   in   C_CHANNELS                     per-channel push request
//  in_data    in   C_CHANNELS*C_DATA_WIDTH        per-channel descriptor, ch0 at LSBs
//  in_ready   out  C_CHANNELS                     per-channel not-full
//  in_afull   out  C_CHANNELS                     level >= C_AFULL_THRESH
//  ch_level   out  C_CHANNELS*(C_DEPTH_LOG2+1)    per-channel occupancy, 0..depth
//  out_valid  out  1                              output descriptor valid
//  out_data   out  C_DATA_WIDTH                   output descriptor
//  out_ch     out  C_CH_W                         source channel of out_data
//  out_ready  in   1                              TX engine accepts
//  err        out  C_CHANNELS                     sticky: push attempted while full
//  err_clr    in   1                              clears all err bits (synchronous)
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert by upstream): all FIFOs empty, pointers 0,
//    in_ready=all 1, in_afull=0, ch_level=0, out_valid=0, out_data=0, out_ch=0, err=0,
//    round-robin pointer = C_CHANNELS-1 (ch0 wins first arbitration).
//  - Push: in_valid[ch]&in_ready[ch] writes in_data slice; level+1 next cycle.
//  - in_ready[ch] = !full[ch], registered-state only, no same-cycle pop lookahead.
//  - in_valid[ch]&!in_ready[ch]: data dropped, err[ch] set next cycle; stays set until
//    err_clr; err_clr and new error same cycle -> err bit set (error wins).
//  - Output stage is one register. Load when (!out_valid | out_ready) and any channel
//    non-empty: pick first non-empty channel after rr pointer (wrap C_CHANNELS-1 -> 0),
//    pop it, load out_data/out_ch, set out_valid, rr pointer := granted channel.
//  - out_valid&!out_ready: out_data/out_ch held stable, no pop, no re-arbitration.
//  - Back-to-back: out_ready held high with data -> one descriptor per clock.
//  - Latency: push to empty block at cycle t -> out_valid at t+2 (FIFO write t, out
//    register load t+1, visible t+2). Zero bubble when FIFO already non-empty.
//  - Simultaneous push and pop on same channel: level unchanged, both take effect;
//    legal at any level including depth-1 and 1.
//  - Pointers are C_DEPTH_LOG2+1 bits; full when MSBs differ and low bits equal;
//    empty when equal. Wrap-around is natural binary overflow.
//  - Pop with channel empty never occurs (arbiter masks empties).
//  - Reset mid-transfer discards all stored and in-flight descriptors; no recovery.
// STRUCTURE
//  - tlp_txcmd_defs.vh: TLP command type codes, channel id constants (CH_MWR=0,
//    CH_MRD=1, CH_CPL=2), default widths; shared with TLP TX engine.
//  - Sub-module tlp_txcmd_chfifo: single-channel sync FIFO (distributed RAM, ptrs,
//    full/empty/level/afull), instantiated C_CHANNELS times via generate.
//  - Top: generate loop, rotate-priority round-robin arbiter, output register, err regs.
// TESTING
//  1. Reset then push 0xA5 on ch1 only -> out_valid at +2 cycles, out_data=0xA5,
//     out_ch=1; ch_level[1] returns to 0.
//  2. All 3 channels hold 4 entries, out_ready=1 -> out_ch sequence 0,1,2,0,1,2,...
//     12 descriptors in 12 consecutive cycles, per-channel order preserved.
//  3. Fill ch0 with 16 entries, out_ready=0 -> in_ready[0]=0, in_afull[0]=1 from
//     level 12; 17th push sets err[0], stored data unchanged; err_clr clears it.
//  4. out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_ch stable, no level
//     change; release -> next descriptor follows in order.
//  5. ch2 at level 15, simultaneous push+pop each cycle for 40 cycles -> level stays
//     15, pointers wrap, data order intact, no err.
//  6. Assert rst mid-burst with 3 entries per channel -> all outputs at reset values
//     immediately; after release first grant is ch0.

Source files
------------

// File: rtl/tlp_txcmd_mfifo_pkg.sv
// Shared definitions for the multi-channel TLP TX command FIFO: default geometry,
// channel ids and command codes common with the TLP TX engine, and arbiter helper.
package tlp_txcmd_mfifo_pkg;

  localparam int DEF_CHANNELS     = 3;
  localparam int DEF_DATA_WIDTH   = 64;
  localparam int DEF_DEPTH_LOG2   = 4;
  localparam int DEF_AFULL_THRESH = 12;
  localparam int DEF_CH_W         = 2;

  typedef enum logic [1:0] {
    CH_MWR = 2'd0,
    CH_MRD = 2'd1,
    CH_CPL = 2'd2
  } tlp_ch_e;

  typedef enum logic [2:0] {
    TLP_CMD_MWR = 3'b000,
    TLP_CMD_MRD = 3'b001,
    TLP_CMD_CPL = 3'b010
  } tlp_cmd_e;

  // Channel visited 'offset' steps after 'ptr' in a ring of 'n' channels.
  function automatic int unsigned rr_index(input int unsigned ptr,
                                           input int unsigned offset,
                                           input int unsigned n);
    return (ptr + offset) % n;
  endfunction

endpackage

// File: rtl/tlp_txcmd_mfifo_if.sv
// Push/drain bundle of the TX command FIFO; master is the producer/TX-engine side,
// slave is the FIFO itself.
interface tlp_txcmd_mfifo_if
  import tlp_txcmd_mfifo_pkg::*;
#(
  parameter int C_CHANNELS   = DEF_CHANNELS,
  parameter int C_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int C_DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int C_CH_W       = DEF_CH_W
);

  logic [C_CHANNELS-1:0]                  in_valid;
  logic [C_CHANNELS*C_DATA_WIDTH-1:0]     in_data;
  logic [C_CHANNELS-1:0]                  in_ready;
  logic [C_CHANNELS-1:0]                  in_afull;
  logic [C_CHANNELS*(C_DEPTH_LOG2+1)-1:0] ch_level;
  logic                                   out_valid;
  logic [C_DATA_WIDTH-1:0]                out_data;
  logic [C_CH_W-1:0]                      out_ch;
  logic                                   out_ready;
  logic [C_CHANNELS-1:0]                  err;
  logic                                   err_clr;

  modport master (
    output in_valid, in_data, out_ready, err_clr,
    input  in_ready, in_afull, ch_level, out_valid, out_data, out_ch, err
  );

  modport slave (
    input  in_valid, in_data, out_ready, err_clr,
    output in_ready, in_afull, ch_level, out_valid, out_data, out_ch, err
  );

endinterface

// File: rtl/tlp_txcmd_mfifo_chfifo.sv
// Single-channel synchronous FIFO with extra-MSB pointers, occupancy and almost-full.
// Caller guarantees push only when !full and pop only when !empty.
module tlp_txcmd_mfifo_chfifo
  import tlp_txcmd_mfifo_pkg::*;
#(
  parameter int DW    = DEF_DATA_WIDTH,
  parameter int AW    = DEF_DEPTH_LOG2,
  parameter int AFULL = DEF_AFULL_THRESH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;
  localparam int LW    = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // NOTE: the storage array is deliberately not reset; the pointers alone say which
  // entries are live, and a resettable array could not map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LW'(1);
      if (pop)  rd_ptr <= rd_ptr + LW'(1);
    end
  end

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign afull    = (level >= LW'(AFULL));
  assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tlp_txcmd_mfifo.sv
// Multi-channel TX command FIFO: per-channel FIFOs drained through a round-robin
// arbiter into a single output register, with sticky overflow error per channel.
module tlp_txcmd_mfifo
  import tlp_txcmd_mfifo_pkg::*;
#(
  parameter int C_CHANNELS     = DEF_CHANNELS,
  parameter int C_DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int C_DEPTH_LOG2   = DEF_DEPTH_LOG2,
  parameter int C_AFULL_THRESH = DEF_AFULL_THRESH,
  parameter int C_CH_W         = DEF_CH_W
) (
  input logic               clk,
  input logic               rst,
  tlp_txcmd_mfifo_if.slave  bus
);

  localparam int LW = C_DEPTH_LOG2 + 1;

  logic [C_CHANNELS-1:0]   full;
  logic [C_CHANNELS-1:0]   empty;
  logic [C_CHANNELS-1:0]   afull;
  logic [C_CHANNELS-1:0]   push;
  logic [C_CHANNELS-1:0]   pop;
  logic [C_DATA_WIDTH-1:0] head  [C_CHANNELS];
  logic [LW-1:0]           level [C_CHANNELS];

  logic [C_CH_W-1:0]       rr_ptr;
  logic                    grant_valid;
  logic [C_CH_W-1:0]       grant_ch;
  logic [C_DATA_WIDTH-1:0] grant_data;
  logic                    load;

  logic                    out_valid_q;
  logic [C_DATA_WIDTH-1:0] out_data_q;
  logic [C_CH_W-1:0]       out_ch_q;
  logic [C_CHANNELS-1:0]   err_q;

  assign push = bus.in_valid & ~full;
  assign load = !out_valid_q || bus.out_ready;

  for (genvar ch = 0; ch < C_CHANNELS; ch++) begin : g_ch
    tlp_txcmd_mfifo_chfifo #(
      .DW    (C_DATA_WIDTH),
      .AW    (C_DEPTH_LOG2),
      .AFULL (C_AFULL_THRESH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[ch]),
      .push_data (bus.in_data[ch*C_DATA_WIDTH +: C_DATA_WIDTH]),
      .pop       (pop[ch]),
      .pop_data  (head[ch]),
      .full      (full[ch]),
      .empty     (empty[ch]),
      .afull     (afull[ch]),
      .level     (level[ch])
    );

    assign pop[ch]                  = load && grant_valid && (grant_ch == C_CH_W'(ch));
    assign bus.ch_level[ch*LW +: LW] = level[ch];
  end

  // Offsets are scanned farthest-first so the nearest non-empty channel after
  // rr_ptr is the last writer and therefore wins.
  // NOTE: every always_comb output gets a default before any branch; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    grant_data  = '0;
    for (int k = C_CHANNELS; k >= 1; k--) begin
      for (int c = 0; c < C_CHANNELS; c++) begin
        if (!empty[c] && rr_index(32'(rr_ptr), k, C_CHANNELS) == c) begin
          grant_valid = 1'b1;
          grant_ch    = C_CH_W'(c);
          grant_data  = head[c];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr      <= C_CH_W'(C_CHANNELS - 1);
    end else if (load) begin
      out_valid_q <= grant_valid;
      if (grant_valid) begin
        out_data_q <= grant_data;
        out_ch_q   <= grant_ch;
        rr_ptr     <= grant_ch;
      end
    end
  end

  // A new overflow in the same cycle as err_clr leaves the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= (bus.err_clr ? '0 : err_q) | (bus.in_valid & full);
  end

  assign bus.in_ready  = ~full;
  assign bus.in_afull  = afull;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.err       = err_q;

endmodule
